// File: rtl/keystone_line_buffer_pkg.sv
// keystone_pkg: shared types and constants for the keystone row buffer.
//   pixel_t  : default-width {r,g,b} pixel
//   coord_t  : default-width signed lookup coordinate
//   bank_idx : maps a row number onto its bank (row mod number of banks)
package keystone_pkg;

   localparam int DEFAULT_WIDTH   = 1920;
   localparam int DEFAULT_HEIGHT  = 1080;
   localparam int DEFAULT_PIX_W   = 24;
   localparam int DEFAULT_COORD_W = 16;

   typedef logic [DEFAULT_PIX_W-1:0]          pixel_t;
   typedef logic signed [DEFAULT_COORD_W-1:0] coord_t;

   // num_rows is a power of two, so the modulo is a mask
   function automatic logic [31:0] bank_idx(input logic [31:0] y, input logic [31:0] num_rows);
      return y & (num_rows - 32'd1);
   endfunction

endpackage

// File: rtl/keystone_line_buffer_if.sv
// keystone_line_buffer_if: pixel write stream and coordinate lookup bus.
//   write stream : wr_valid/wr_ready handshake, wr_pixel, wr_sof, wr_eol
//   lookup       : rd_req, rd_x, rd_y (signed) -> rd_valid, rd_pixel, rd_in_range
//   master drives requests and pixels, slave (the buffer) answers.
interface keystone_line_buffer_if
   import keystone_pkg::*;
#(
   parameter int PIX_W   = DEFAULT_PIX_W,
   parameter int COORD_W = DEFAULT_COORD_W
);
   logic                      wr_valid;
   logic                      wr_ready;
   logic [PIX_W-1:0]          wr_pixel;
   logic                      wr_sof;
   logic                      wr_eol;
   logic                      rd_req;
   logic signed [COORD_W-1:0] rd_x;
   logic signed [COORD_W-1:0] rd_y;
   logic                      rd_valid;
   logic [PIX_W-1:0]          rd_pixel;
   logic                      rd_in_range;

   modport master (
      output wr_valid, wr_pixel, wr_sof, wr_eol, rd_req, rd_x, rd_y,
      input  wr_ready, rd_valid, rd_pixel, rd_in_range
   );

   modport slave (
      input  wr_valid, wr_pixel, wr_sof, wr_eol, rd_req, rd_x, rd_y,
      output wr_ready, rd_valid, rd_pixel, rd_in_range
   );
endinterface

// File: rtl/keystone_bank_ram.sv
// keystone_bank_ram: one row of pixels, simple dual-port, registered read.
//   clock        : single clock
//   we/waddr/wdata : write port
//   re/raddr     : read port; rdata updates the cycle after re
//   Contents are not reset.
module keystone_bank_ram
   import keystone_pkg::*;
#(
   parameter int  DEPTH = DEFAULT_WIDTH,
   parameter int  DW    = DEFAULT_PIX_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // write port
   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // registered read port
   always_ff @(posedge clock) begin
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/keystone_line_buffer.sv
// keystone_line_buffer: rolling buffer of NUM_ROWS completed rows for the keystone
// datapath, one bank per row, with 2-cycle bounds-checked (x,y) lookups.
//   clock, reset     : single clock, asynchronous active-high reset
//   bus (slave)      : pixel write stream + lookup request/result
//   row_release      : consumer done with the oldest held row
//   clear_err        : clears sticky stream_err
//   row_base         : y of the oldest held row
//   rows_held        : completed rows resident
//   frame_done       : one-cycle pulse when the last row of a frame completes
//   stream_err       : sticky protocol error
// Optional feature macro KEYSTONE_BORDER_COLOR_EN adds input border_color, returned
// for out-of-range lookups (sampled at request time) instead of zero.
module keystone_line_buffer
   import keystone_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int HEIGHT   = DEFAULT_HEIGHT,
   parameter int NUM_ROWS = 8,
   parameter int PIX_W    = DEFAULT_PIX_W,
   parameter int COORD_W  = DEFAULT_COORD_W
) (
   input  logic                          clock,
   input  logic                          reset,
   keystone_line_buffer_if.slave         bus,
   input  logic                          row_release,
   input  logic                          clear_err,
`ifdef KEYSTONE_BORDER_COLOR_EN
   input  logic [PIX_W-1:0]              border_color,
`endif
   output logic [COORD_W-1:0]            row_base,
   output logic [$clog2(NUM_ROWS+1)-1:0] rows_held,
   output logic                          frame_done,
   output logic                          stream_err
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT + 1);
   localparam int HW = $clog2(NUM_ROWS + 1);
   localparam int BW = $clog2(NUM_ROWS);

   logic [XW-1:0]      wr_x_q, wr_x_d, x_eff_s;
   logic [YW-1:0]      wr_y_q, wr_y_d, y_eff_s;
   logic [HW-1:0]      rows_held_q, rows_held_d, held_eff_s;
   logic [COORD_W-1:0] row_base_q, row_base_d, base_eff_s;
   logic               wr_ready_q, wr_ready_d;
   logic               frame_done_q, frame_done_d;
   logic               stream_err_q, stream_err_d;
   logic               accept_s, sof_acc_s, wr_en_s, row_end_s, err_s, rel_apply_s;
   logic [BW-1:0]      wr_bank_s, rd_bank_s;
   logic               rd_hit_s;
   int                 x_i_s, y_i_s, base_i_s, top_i_s;
   logic [PIX_W-1:0]   oor_pix_s;
   logic [PIX_W-1:0]   bank_dout_s [NUM_ROWS];

   logic               s1_valid_q, s1_hit_q;
   logic [BW-1:0]      s1_bank_q;
   logic [PIX_W-1:0]   s1_oor_q;
   logic               rd_valid_q, rd_in_range_q, rd_in_range_d;
   logic [PIX_W-1:0]   rd_pixel_q, rd_pixel_d;

`ifdef KEYSTONE_BORDER_COLOR_EN
   assign oor_pix_s = border_color;
`else
   assign oor_pix_s = {PIX_W{1'b0}};
`endif

   // Write-side control: accept, row end, protocol errors and row accounting
   always_comb begin
      accept_s     = bus.wr_valid & wr_ready_q;
      sof_acc_s    = accept_s & bus.wr_sof;
      wr_en_s      = 1'b0;
      row_end_s    = 1'b0;
      err_s        = 1'b0;
      rel_apply_s  = 1'b0;
      wr_x_d       = wr_x_q;
      wr_y_d       = wr_y_q;
      frame_done_d = 1'b0;
      // a start-of-frame pixel restarts all accounting before it is placed
      if (sof_acc_s) begin
         x_eff_s    = XW'(0);
         y_eff_s    = YW'(0);
         held_eff_s = HW'(0);
         base_eff_s = COORD_W'(0);
      end else begin
         x_eff_s    = wr_x_q;
         y_eff_s    = wr_y_q;
         held_eff_s = rows_held_q;
         base_eff_s = row_base_q;
      end
      if (accept_s) begin
         if (!bus.wr_sof && (wr_y_q == YW'(HEIGHT))) begin
            // frame already complete: pixel is dropped until the next sof
            err_s = 1'b1;
         end else begin
            wr_en_s   = 1'b1;
            row_end_s = bus.wr_eol | (x_eff_s == XW'(WIDTH - 1));
            // eol must coincide exactly with the last column
            err_s     = bus.wr_eol ^ (x_eff_s == XW'(WIDTH - 1));
            if (row_end_s) begin
               wr_x_d       = XW'(0);
               wr_y_d       = y_eff_s + YW'(1);
               frame_done_d = (y_eff_s == YW'(HEIGHT - 1));
            end else begin
               wr_x_d       = x_eff_s + XW'(1);
               wr_y_d       = y_eff_s;
               frame_done_d = 1'b0;
            end
         end
      end else begin
         wr_en_s = 1'b0;
      end
      // releasing an empty buffer is an error; a same-cycle sof supersedes a release
      if (row_release) begin
         if (rows_held_q == HW'(0)) begin
            err_s = 1'b1;
         end else begin
            rel_apply_s = ~sof_acc_s;
         end
      end else begin
         rel_apply_s = 1'b0;
      end
      rows_held_d = held_eff_s + HW'(row_end_s) - HW'(rel_apply_s);
      row_base_d  = base_eff_s + COORD_W'(rel_apply_s);
      wr_ready_d  = (int'(rows_held_d) < NUM_ROWS);
      // a new error wins over a same-cycle clear
      if (err_s) begin
         stream_err_d = 1'b1;
      end else if (clear_err) begin
         stream_err_d = 1'b0;
      end else begin
         stream_err_d = stream_err_q;
      end
      wr_bank_s = BW'(bank_idx(32'(y_eff_s), 32'(NUM_ROWS)));
   end

   // Lookup range check against the row window held in the request cycle
   always_comb begin
      x_i_s     = int'(bus.rd_x);
      y_i_s     = int'(bus.rd_y);
      base_i_s  = int'(row_base_q);
      top_i_s   = base_i_s + int'(rows_held_q);
      rd_hit_s  = bus.rd_req && (x_i_s >= 0) && (x_i_s < WIDTH) &&
                  (y_i_s >= base_i_s) && (y_i_s < top_i_s) && (y_i_s < HEIGHT);
      rd_bank_s = BW'(bank_idx(32'(bus.rd_y), 32'(NUM_ROWS)));
   end

   for (genvar b = 0; b < NUM_ROWS; b++) begin : g_bank
      keystone_bank_ram #(.DEPTH(WIDTH), .DW(PIX_W)) u_ram (
         .clock (clock),
         .we    (wr_en_s && (wr_bank_s == BW'(b))),
         .waddr (x_eff_s),
         .wdata (bus.wr_pixel),
         .re    (rd_hit_s && (rd_bank_s == BW'(b))),
         .raddr (bus.rd_x[XW-1:0]),
         .rdata (bank_dout_s[b])
      );
   end

   // Result stage: select the bank read out or the out-of-range value
   always_comb begin
      if (s1_valid_q) begin
         rd_in_range_d = s1_hit_q;
         if (s1_hit_q) begin
            rd_pixel_d = bank_dout_s[s1_bank_q];
         end else begin
            rd_pixel_d = s1_oor_q;
         end
      end else begin
         rd_in_range_d = rd_in_range_q;
         rd_pixel_d    = rd_pixel_q;
      end
   end

   // Write-side state registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_x_q       <= XW'(0);
         wr_y_q       <= YW'(0);
         rows_held_q  <= HW'(0);
         row_base_q   <= COORD_W'(0);
         wr_ready_q   <= 1'b1;
         frame_done_q <= 1'b0;
         stream_err_q <= 1'b0;
      end else begin
         wr_x_q       <= wr_x_d;
         wr_y_q       <= wr_y_d;
         rows_held_q  <= rows_held_d;
         row_base_q   <= row_base_d;
         wr_ready_q   <= wr_ready_d;
         frame_done_q <= frame_done_d;
         stream_err_q <= stream_err_d;
      end
   end

   // Lookup pipeline registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q    <= 1'b0;
         s1_hit_q      <= 1'b0;
         s1_bank_q     <= BW'(0);
         s1_oor_q      <= {PIX_W{1'b0}};
         rd_valid_q    <= 1'b0;
         rd_in_range_q <= 1'b0;
         rd_pixel_q    <= {PIX_W{1'b0}};
      end else begin
         s1_valid_q    <= bus.rd_req;
         s1_hit_q      <= rd_hit_s;
         s1_bank_q     <= rd_bank_s;
         s1_oor_q      <= oor_pix_s;
         rd_valid_q    <= s1_valid_q;
         rd_in_range_q <= rd_in_range_d;
         rd_pixel_q    <= rd_pixel_d;
      end
   end

   assign bus.wr_ready    = wr_ready_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_pixel    = rd_pixel_q;
   assign bus.rd_in_range = rd_in_range_q;
   assign row_base        = row_base_q;
   assign rows_held       = rows_held_q;
   assign frame_done      = frame_done_q;
   assign stream_err      = stream_err_q;
endmodule

// File: tb/tb_keystone_line_buffer.sv
// Directed bench for keystone_line_buffer with WIDTH=8, HEIGHT=6, NUM_ROWS=4.
// Pixel written at (x,y) carries offset + y*16 + x.
module tb_keystone_line_buffer;
   logic        clock;
   logic        reset;
   logic        row_release;
   logic        clear_err;
   logic [15:0] row_base;
   logic [2:0]  rows_held;
   logic        frame_done;
   logic        stream_err;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          fd_cnt   = 0;

`ifdef KEYSTONE_BORDER_COLOR_EN
   logic [23:0] border_color;
   localparam logic [23:0] OOR_PIX = 24'hABCDEF;
`else
   localparam logic [23:0] OOR_PIX = 24'h000000;
`endif

   keystone_line_buffer_if #(.PIX_W(24), .COORD_W(16)) bus ();

   keystone_line_buffer #(.WIDTH(8), .HEIGHT(6), .NUM_ROWS(4), .PIX_W(24), .COORD_W(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .row_release (row_release),
      .clear_err   (clear_err),
`ifdef KEYSTONE_BORDER_COLOR_EN
      .border_color(border_color),
`endif
      .row_base    (row_base),
      .rows_held   (rows_held),
      .frame_done  (frame_done),
      .stream_err  (stream_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(negedge clock) begin
      if (frame_done) fd_cnt <= fd_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [23:0] pix, input logic sof, input logic eol);
      int n;
      n = 0;
      bus.wr_valid = 1'b1;
      bus.wr_pixel = pix;
      bus.wr_sof   = sof;
      bus.wr_eol   = eol;
      while (!bus.wr_ready && n < 20) begin
         tick();
         n++;
      end
      if (!bus.wr_ready) check_eq("wr_ready_wait", 32'(bus.wr_ready), 32'd1);
      tick();
      bus.wr_valid = 1'b0;
      bus.wr_sof   = 1'b0;
      bus.wr_eol   = 1'b0;
   endtask

   task automatic write_row(input int y, input int eol_x, input logic sof, input logic [23:0] off);
      for (int x = 0; x < 8; x++) begin
         push(off + 24'(y * 16 + x), sof && (x == 0), x == eol_x);
         if (x == eol_x) break;
      end
   endtask

   task automatic release_row();
      row_release = 1'b1;
      tick();
      row_release = 1'b0;
   endtask

   task automatic clear();
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
   endtask

   task automatic do_read(input string tag, input int x, input int y, input logic exp_in,
                          input logic [23:0] exp_pix);
      bus.rd_req = 1'b1;
      bus.rd_x   = 16'(x);
      bus.rd_y   = 16'(y);
      tick();
      bus.rd_req = 1'b0;
      check_eq({tag, "_valid_n1"}, 32'(bus.rd_valid), 32'd0);
      tick();
      check_eq({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
      check_eq({tag, "_in_range"}, 32'(bus.rd_in_range), 32'(exp_in));
      check_eq({tag, "_pixel"}, 32'(bus.rd_pixel), 32'(exp_pix));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      row_release  = 1'b0;
      clear_err    = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_pixel = 24'h0;
      bus.wr_sof   = 1'b0;
      bus.wr_eol   = 1'b0;
      bus.rd_req   = 1'b0;
      bus.rd_x     = 16'sd0;
      bus.rd_y     = 16'sd0;
`ifdef KEYSTONE_BORDER_COLOR_EN
      border_color = OOR_PIX;
`endif
      tick();
      tick();
      check_eq("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
      check_eq("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      check_eq("rst_rd_pixel", 32'(bus.rd_pixel), 32'd0);
      check_eq("rst_rows_held", 32'(rows_held), 32'd0);
      check_eq("rst_row_base", 32'(row_base), 32'd0);
      check_eq("rst_stream_err", 32'(stream_err), 32'd0);
      check_eq("rst_frame_done", 32'(frame_done), 32'd0);
      reset = 1'b0;

      // 1: first row, lookup latency and data
      write_row(0, 7, 1'b1, 24'h0);
      check_eq("t1_rows_held", 32'(rows_held), 32'd1);
      do_read("t1_rd30", 3, 0, 1'b1, 24'h000003);

      // 2: fill, stall, release
      write_row(1, 7, 1'b0, 24'h0);
      write_row(2, 7, 1'b0, 24'h0);
      write_row(3, 7, 1'b0, 24'h0);
      check_eq("t2_rows_held_full", 32'(rows_held), 32'd4);
      check_eq("t2_wr_ready_full", 32'(bus.wr_ready), 32'd0);
      bus.wr_valid = 1'b1;
      bus.wr_pixel = 24'h000040;
      tick();
      tick();
      tick();
      check_eq("t2_stall_ready", 32'(bus.wr_ready), 32'd0);
      check_eq("t2_stall_held", 32'(rows_held), 32'd4);
      release_row();
      check_eq("t2_rel_base", 32'(row_base), 32'd1);
      check_eq("t2_rel_held", 32'(rows_held), 32'd3);
      check_eq("t2_rel_ready", 32'(bus.wr_ready), 32'd1);
      tick();
      bus.wr_valid = 1'b0;
      for (int x = 1; x < 8; x++) push(24'h000040 + 24'(x), 1'b0, x == 7);
      check_eq("t2_row4_held", 32'(rows_held), 32'd4);
      do_read("t2_rd04", 0, 4, 1'b1, 24'h000040);
      do_read("t2_rd71", 7, 1, 1'b1, 24'h000017);

      // 3: range boundaries (window is rows 1..4)
      do_read("t3_xneg", -1, 1, 1'b0, OOR_PIX);
      do_read("t3_xwide", 8, 1, 1'b0, OOR_PIX);
      do_read("t3_ytop", 0, 5, 1'b0, OOR_PIX);
      do_read("t3_ybelow", 0, 0, 1'b0, OOR_PIX);
      do_read("t3_rd74", 7, 4, 1'b1, 24'h000047);
      do_read("t3_rd01", 0, 1, 1'b1, 24'h000010);

      // 4: short row, clear, empty release, row end without eol
      release_row();
      write_row(0, 5, 1'b1, 24'h0);
      check_eq("t4_short_err", 32'(stream_err), 32'd1);
      check_eq("t4_short_held", 32'(rows_held), 32'd1);
      check_eq("t4_short_base", 32'(row_base), 32'd0);
      do_read("t4_rd50", 5, 0, 1'b1, 24'h000005);
      clear();
      check_eq("t4_clear", 32'(stream_err), 32'd0);
      release_row();
      check_eq("t4_rel_held", 32'(rows_held), 32'd0);
      check_eq("t4_rel_base", 32'(row_base), 32'd1);
      check_eq("t4_rel_noerr", 32'(stream_err), 32'd0);
      release_row();
      check_eq("t4_empty_rel_err", 32'(stream_err), 32'd1);
      check_eq("t4_empty_rel_base", 32'(row_base), 32'd1);
      check_eq("t4_empty_rel_held", 32'(rows_held), 32'd0);
      clear();
      write_row(1, -1, 1'b0, 24'h0);
      check_eq("t4_noeol_err", 32'(stream_err), 32'd1);
      check_eq("t4_noeol_held", 32'(rows_held), 32'd1);
      do_read("t4_rd71", 7, 1, 1'b1, 24'h000017);
      clear();

      // 5: full frame, frame_done, dropped pixel, clear vs error
      for (int y = 0; y < 5; y++) begin
         write_row(y, 7, y == 0, 24'h0);
         release_row();
      end
      check_eq("t5_fd_before", 32'(fd_cnt), 32'd0);
      write_row(5, 7, 1'b0, 24'h0);
      check_eq("t5_fd_pulse", 32'(frame_done), 32'd1);
      release_row();
      check_eq("t5_fd_low", 32'(frame_done), 32'd0);
      check_eq("t5_fd_count", 32'(fd_cnt), 32'd1);
      check_eq("t5_frame_err", 32'(stream_err), 32'd0);
      clear_err = 1'b1;
      push(24'h000999, 1'b0, 1'b0);
      clear_err = 1'b0;
      check_eq("t5_drop_err", 32'(stream_err), 32'd1);
      check_eq("t5_drop_held", 32'(rows_held), 32'd0);

      // 6: asynchronous reset mid-row with a lookup in flight
      write_row(0, 7, 1'b1, 24'h0);
      write_row(1, 7, 1'b0, 24'h0);
      write_row(2, 7, 1'b0, 24'h0);
      release_row();
      push(24'h000030, 1'b0, 1'b0);
      push(24'h000031, 1'b0, 1'b0);
      do_read("t6_rd32", 3, 2, 1'b1, 24'h000023);
      check_eq("t6_pre_err", 32'(stream_err), 32'd1);
      bus.rd_req = 1'b1;
      bus.rd_x   = 16'sd1;
      bus.rd_y   = 16'sd1;
      tick();
      bus.rd_req = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_eq("t6_wr_ready", 32'(bus.wr_ready), 32'd1);
      check_eq("t6_rows_held", 32'(rows_held), 32'd0);
      check_eq("t6_row_base", 32'(row_base), 32'd0);
      check_eq("t6_rd_pixel", 32'(bus.rd_pixel), 32'd0);
      check_eq("t6_rd_in_range", 32'(bus.rd_in_range), 32'd0);
      check_eq("t6_stream_err", 32'(stream_err), 32'd0);
      tick();
      check_eq("t6_flushed", 32'(bus.rd_valid), 32'd0);
      reset = 1'b0;
      write_row(0, 7, 1'b1, 24'h000100);
      check_eq("t6_restart_held", 32'(rows_held), 32'd1);
      do_read("t6_rd50", 5, 0, 1'b1, 24'h000105);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
